// File: rtl/axis_fifo_width_adapter.sv
// AXI4-Stream FIFO that packs narrow input beats into wide words, with optional
// store-and-forward framing (bad-frame and overflow drop).
module axis_fifo_width_adapter #(
    parameter int                    DEPTH                = 32,
    parameter int                    S_DATA_WIDTH         = 8,
    parameter bit                    S_KEEP_ENABLE        = (S_DATA_WIDTH > 8),
    parameter int                    S_KEEP_WIDTH         = S_DATA_WIDTH / 8,
    parameter int                    M_DATA_WIDTH         = 64,
    parameter bit                    M_KEEP_ENABLE        = (M_DATA_WIDTH > 8),
    parameter int                    M_KEEP_WIDTH         = M_DATA_WIDTH / 8,
    parameter bit                    ID_ENABLE            = 1,
    parameter int                    ID_WIDTH             = 8,
    parameter bit                    DEST_ENABLE          = 1,
    parameter int                    DEST_WIDTH           = 8,
    parameter bit                    USER_ENABLE          = 1,
    parameter int                    USER_WIDTH           = 1,
    parameter int                    PIPELINE_OUTPUT      = 2,
    parameter bit                    FRAME_FIFO           = 0,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
    parameter bit                    DROP_BAD_FRAME       = 0,
    parameter bit                    DROP_WHEN_FULL       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    status_overflow,
    output logic                    status_bad_frame,
    output logic                    status_good_frame
);
    localparam int RATIO      = M_DATA_WIDTH / S_DATA_WIDTH;
    localparam int WORD_DEPTH = DEPTH / M_KEEP_WIDTH;
    localparam int AW         = $clog2(WORD_DEPTH);
    localparam int CW         = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int P          = PIPELINE_OUTPUT;
    localparam logic [AW:0] PTR_DEPTH = (AW + 1)'(WORD_DEPTH);

    typedef struct packed {
        logic [USER_WIDTH-1:0]   user;
        logic [DEST_WIDTH-1:0]   dest;
        logic [ID_WIDTH-1:0]     id;
        logic                    last;
        logic [M_KEEP_WIDTH-1:0] keep;
        logic [M_DATA_WIDTH-1:0] data;
    } word_t;

    logic [M_DATA_WIDTH-1:0] pk_data_q, pk_data_d;
    logic [M_KEEP_WIDTH-1:0] pk_keep_q, pk_keep_d;
    logic [CW-1:0]           pk_cnt_q, pk_cnt_d;
    logic [ID_WIDTH-1:0]     pk_id_q, pk_id_d;
    logic [DEST_WIDTH-1:0]   pk_dest_q, pk_dest_d;
    word_t                   stg_q, stg_d;
    logic                    stg_v_q, stg_v_d;
    logic [AW:0]             wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d, fe_ptr_q, fe_ptr_d, rd_limit;
    logic                    drop_q, drop_d, in_en_q;
    logic                    ovf_q, ovf_d, bad_q, bad_d, good_q, good_d;
    word_t                   mem_q [WORD_DEPTH];
    word_t                   pipe_q [P];
    word_t                   pipe_d [P];
    logic [P-1:0]            pipe_v_q, pipe_v_d, pipe_rdy;
    logic                    full, too_big, drop_now, consume, do_write, beat, fetch, frame_bad, rdy_chain;
    logic [S_KEEP_WIDTH-1:0] keep_in;
    logic [ID_WIDTH-1:0]     id_in;
    logic [DEST_WIDTH-1:0]   dest_in;
    logic [USER_WIDTH-1:0]   user_in;

    // Occupancy counts words until they leave the output port, so the pipeline stages
    // are part of the DEPTH budget and full depends only on registered pointers.
    assign full      = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign too_big   = FRAME_FIFO && ((wr_ptr_q - cm_ptr_q) == PTR_DEPTH);
    assign drop_now  = stg_v_q && !drop_q && (too_big || (FRAME_FIFO && DROP_WHEN_FULL && full));
    assign consume   = drop_q || drop_now || !full;
    assign do_write  = stg_v_q && !drop_q && !drop_now && !full;
    assign frame_bad = (stg_q.user & USER_BAD_FRAME_MASK) == (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK);

    assign s_axis_tready = in_en_q && (!stg_v_q || consume);
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign keep_in       = S_KEEP_ENABLE ? s_axis_tkeep : '1;
    assign id_in         = ID_ENABLE ? s_axis_tid : '0;
    assign dest_in       = DEST_ENABLE ? s_axis_tdest : '0;
    assign user_in       = USER_ENABLE ? s_axis_tuser : '0;

    always_comb begin
        pk_data_d = pk_data_q;
        pk_keep_d = pk_keep_q;
        pk_cnt_d  = pk_cnt_q;
        pk_id_d   = pk_id_q;
        pk_dest_d = pk_dest_q;
        stg_d     = stg_q;
        stg_v_d   = stg_v_q && !consume;
        if (beat) begin
            pk_data_d[pk_cnt_q*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
            pk_keep_d[pk_cnt_q*S_KEEP_WIDTH +: S_KEEP_WIDTH] = keep_in;
            if (pk_cnt_q == '0) begin
                pk_id_d   = id_in;
                pk_dest_d = dest_in;
            end
            if (s_axis_tlast || pk_cnt_q == CW'(RATIO - 1)) begin
                stg_v_d    = 1'b1;
                stg_d.data = pk_data_d;
                stg_d.keep = pk_keep_d;
                stg_d.last = s_axis_tlast;
                stg_d.id   = pk_id_d;
                stg_d.dest = pk_dest_d;
                stg_d.user = user_in;
                pk_data_d  = '0;
                pk_keep_d  = '0;
                pk_cnt_d   = '0;
            end else begin
                pk_cnt_d = pk_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        drop_d   = drop_q;
        ovf_d    = 1'b0;
        bad_d    = 1'b0;
        good_d   = 1'b0;
        if (stg_v_q) begin
            if (drop_q || drop_now) begin
                wr_ptr_d = cm_ptr_q;
                drop_d   = !stg_q.last;
                ovf_d    = stg_q.last;
            end else if (!full) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (stg_q.last) begin
                    bad_d  = frame_bad;
                    good_d = !frame_bad;
                    if (FRAME_FIFO) begin
                        if (DROP_BAD_FRAME && frame_bad) wr_ptr_d = cm_ptr_q;
                        else                             cm_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
        end
    end

    // Output pipeline: stage 0 fetches from memory, stage P-1 drives the port.
    always_comb begin
        rd_limit  = FRAME_FIFO ? cm_ptr_q : wr_ptr_q;
        rdy_chain = m_axis_tready;
        pipe_rdy  = '0;
        for (int i = P - 1; i >= 0; i--) begin
            pipe_rdy[i] = !pipe_v_q[i] || rdy_chain;
            rdy_chain   = pipe_rdy[i];
        end
        fetch    = pipe_rdy[0] && (fe_ptr_q != rd_limit);
        pipe_d   = pipe_q;
        pipe_v_d = pipe_v_q;
        if (pipe_rdy[0]) begin
            pipe_v_d[0] = fetch;
            pipe_d[0]   = mem_q[fe_ptr_q[AW-1:0]];
        end
        for (int i = 1; i < P; i++) begin
            if (pipe_rdy[i]) begin
                pipe_v_d[i] = pipe_v_q[i-1];
                pipe_d[i]   = pipe_q[i-1];
            end
        end
        fe_ptr_d = fetch ? fe_ptr_q + 1'b1 : fe_ptr_q;
        rd_ptr_d = (m_axis_tvalid && m_axis_tready) ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_data_q <= '0;
            pk_keep_q <= '0;
            pk_cnt_q  <= '0;
            pk_id_q   <= '0;
            pk_dest_q <= '0;
            stg_q     <= '0;
            stg_v_q   <= 1'b0;
            wr_ptr_q  <= '0;
            cm_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fe_ptr_q  <= '0;
            drop_q    <= 1'b0;
            in_en_q   <= 1'b0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
            good_q    <= 1'b0;
            pipe_v_q  <= '0;
            for (int i = 0; i < P; i++) pipe_q[i] <= '0;
        end else begin
            pk_data_q <= pk_data_d;
            pk_keep_q <= pk_keep_d;
            pk_cnt_q  <= pk_cnt_d;
            pk_id_q   <= pk_id_d;
            pk_dest_q <= pk_dest_d;
            stg_q     <= stg_d;
            stg_v_q   <= stg_v_d;
            wr_ptr_q  <= wr_ptr_d;
            cm_ptr_q  <= cm_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fe_ptr_q  <= fe_ptr_d;
            drop_q    <= drop_d;
            in_en_q   <= 1'b1;
            ovf_q     <= ovf_d;
            bad_q     <= bad_d;
            good_q    <= good_d;
            pipe_v_q  <= pipe_v_d;
            for (int i = 0; i < P; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= stg_q;
    end

    assign m_axis_tvalid     = pipe_v_q[P-1];
    assign m_axis_tdata      = pipe_q[P-1].data;
    assign m_axis_tkeep      = M_KEEP_ENABLE ? pipe_q[P-1].keep : '1;
    assign m_axis_tlast      = pipe_q[P-1].last;
    assign m_axis_tid        = pipe_q[P-1].id;
    assign m_axis_tdest      = pipe_q[P-1].dest;
    assign m_axis_tuser      = pipe_q[P-1].user;
    assign status_overflow   = ovf_q;
    assign status_bad_frame  = bad_q;
    assign status_good_frame = good_q;
endmodule

// File: tb/tb_axis_fifo_width_adapter.sv
// Scoreboard bench: a default-parameter instance and a store-and-forward instance
// that drops bad frames, both checked against a byte-level frame model.
module tb_axis_fifo_width_adapter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [7:0]  s_tdata, f_s_tdata;
    logic [0:0]  s_tkeep, f_s_tkeep;
    logic        s_tvalid, s_tready, s_tlast, f_s_tvalid, f_s_tready, f_s_tlast;
    logic [7:0]  s_tid, s_tdest, f_s_tid, f_s_tdest;
    logic [0:0]  s_tuser, f_s_tuser;
    logic [63:0] m_tdata, f_m_tdata;
    logic [7:0]  m_tkeep, f_m_tkeep;
    logic        m_tvalid, m_tready, m_tlast, f_m_tvalid, f_m_tready, f_m_tlast;
    logic [7:0]  m_tid, m_tdest, f_m_tid, f_m_tdest;
    logic [0:0]  m_tuser, f_m_tuser;
    logic        st_ovf, st_bad, st_good, f_st_ovf, f_st_bad, f_st_good;

    axis_fifo_width_adapter dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .status_overflow(st_ovf), .status_bad_frame(st_bad), .status_good_frame(st_good)
    );

    axis_fifo_width_adapter #(.FRAME_FIFO(1), .DROP_BAD_FRAME(1)) dut_frame (
        .clk(clk), .rst(rst),
        .s_axis_tdata(f_s_tdata), .s_axis_tkeep(f_s_tkeep), .s_axis_tvalid(f_s_tvalid),
        .s_axis_tready(f_s_tready), .s_axis_tlast(f_s_tlast), .s_axis_tid(f_s_tid),
        .s_axis_tdest(f_s_tdest), .s_axis_tuser(f_s_tuser),
        .m_axis_tdata(f_m_tdata), .m_axis_tkeep(f_m_tkeep), .m_axis_tvalid(f_m_tvalid),
        .m_axis_tready(f_m_tready), .m_axis_tlast(f_m_tlast), .m_axis_tid(f_m_tid),
        .m_axis_tdest(f_m_tdest), .m_axis_tuser(f_m_tuser),
        .status_overflow(f_st_ovf), .status_bad_frame(f_st_bad), .status_good_frame(f_st_good)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [0:0]  user;
    } word_t;

    word_t      exp_q[$];
    word_t      exp2_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         good_seen[2], bad_seen[2], ovf_seen[2];
    int         exp_good0 = 0, exp_bad0 = 0;
    logic [7:0] pat[64];
    logic [0:0] upat[64];
    bit         rand_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor(input int sel);
        word_t       act, e;
        logic [63:0] mask;
        logic        v;
        int          nw = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sel == 0) begin
                    v   = m_tvalid && m_tready;
                    act = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
                    if (st_good) good_seen[0]++;
                    if (st_bad)  bad_seen[0]++;
                    if (st_ovf)  ovf_seen[0]++;
                end else begin
                    v   = f_m_tvalid && f_m_tready;
                    act = {f_m_tdata, f_m_tkeep, f_m_tlast, f_m_tid, f_m_tdest, f_m_tuser};
                    if (f_st_good) good_seen[1]++;
                    if (f_st_bad)  bad_seen[1]++;
                    if (f_st_ovf)  ovf_seen[1]++;
                end
                if (v) begin
                    n_checks++;
                    nw++;
                    if ((sel == 0 && exp_q.size() == 0) || (sel == 1 && exp2_q.size() == 0)) begin
                        n_fail++;
                        $display("FAIL unexpected_word sel%0d: got data=%h keep=%h last=%b, required none", sel, act.data, act.keep, act.last);
                    end else begin
                        e = (sel == 0) ? exp_q.pop_front() : exp2_q.pop_front();
                        for (int k = 0; k < 8; k++) mask[8*k +: 8] = {8{e.keep[k]}};
                        if (((act.data & mask) !== (e.data & mask)) || act.keep !== e.keep || act.last !== e.last ||
                            act.id !== e.id || act.dest !== e.dest || act.user !== e.user) begin
                            n_fail++;
                            $display("FAIL word%0d sel%0d: got data=%h keep=%h last=%b id=%h dest=%h user=%b, required data=%h keep=%h last=%b id=%h dest=%h user=%b",
                                     nw, sel, act.data & mask, act.keep, act.last, act.id, act.dest, act.user,
                                     e.data & mask, e.keep, e.last, e.id, e.dest, e.user);
                        end
                    end
                end
            end
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Model: a frame of len bytes becomes ceil(len/8) words, little-endian, last word partial.
    task automatic send_frame(input int sel, input int len, input logic [7:0] id, input logic [7:0] dest,
                              input bit trunc, input bit push, input int gap);
        word_t w;
        int    n, budget;
        logic  ok;
        if (push && !trunc) begin
            for (int b = 0; b < len; b += 8) begin
                n = (len - b < 8) ? len - b : 8;
                w = '0;
                for (int k = 0; k < n; k++) w.data[8*k +: 8] = pat[b+k];
                w.keep = 8'((1 << n) - 1);
                w.last = (b + n == len);
                w.id   = id;
                w.dest = dest;
                w.user = upat[b+n-1];
                if (sel == 0) exp_q.push_back(w);
                else          exp2_q.push_back(w);
            end
            if (sel == 0) begin
                if (upat[len-1] == 1'b1) exp_bad0++;
                else                     exp_good0++;
            end
        end
        for (int i = 0; i < len; i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                @(posedge clk);
                #1;
            end
            if (sel == 0) begin
                s_tdata = pat[i]; s_tlast = !trunc && (i == len - 1); s_tid = id;
                s_tdest = dest; s_tuser = upat[i]; s_tvalid = 1'b1;
            end else begin
                f_s_tdata = pat[i]; f_s_tlast = !trunc && (i == len - 1); f_s_tid = id;
                f_s_tdest = dest; f_s_tuser = upat[i]; f_s_tvalid = 1'b1;
            end
            budget = 500;
            do begin
                @(negedge clk);
                ok = (sel == 0) ? s_tready : f_s_tready;
                @(posedge clk);
                #1;
                budget--;
            end while (!ok && budget > 0);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_accept sel%0d byte%0d: got no s_axis_tready, required acceptance", sel, i);
            end
            s_tvalid   = 1'b0;
            f_s_tvalid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int sel, input int budget);
        int c = 0;
        while (((sel == 0) ? exp_q.size() : exp2_q.size()) != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check($sformatf("drain_sel%0d", sel), 64'((sel == 0) ? exp_q.size() : exp2_q.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int len;
        rst = 1'b1; m_tready = 1'b0; f_m_tready = 1'b1;
        s_tdata = '0; s_tkeep = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tid = '0; s_tdest = '0; s_tuser = '0;
        f_s_tdata = '0; f_s_tkeep = 1'b1; f_s_tvalid = 1'b0; f_s_tlast = 1'b0; f_s_tid = '0; f_s_tdest = '0; f_s_tuser = '0;
        for (int i = 0; i < 2; i++) begin good_seen[i] = 0; bad_seen[i] = 0; ovf_seen[i] = 0; end
        fork
            monitor(0);
            monitor(1);
            ready_gen();
        join_none
        idle(3);
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_status", 64'({st_ovf, st_bad, st_good}), 64'd0);
        check("rst_frame_m_tvalid", 64'(f_m_tvalid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_tready = 1'b1;

        // 8-byte frame -> one full word
        for (int i = 0; i < 8; i++) begin pat[i] = 8'(i + 1); upat[i] = 1'b0; end
        send_frame(0, 8, 8'd5, 8'd7, 0, 1, 0);
        wait_drain(0, 100);

        // 3-byte frame flagged bad -> partial word
        pat[0] = 8'hAA; pat[1] = 8'hBB; pat[2] = 8'hCC;
        upat[0] = 1'b0; upat[1] = 1'b0; upat[2] = 1'b1;
        send_frame(0, 3, 8'd1, 8'd2, 0, 1, 0);
        wait_drain(0, 100);
        idle(4);
        check("t2_bad_pulses", 64'(bad_seen[0]), 64'(exp_bad0));
        check("t2_good_pulses", 64'(good_seen[0]), 64'(exp_good0));

        // output stalled: 40 bytes fill the FIFO and back-pressure the input
        m_tready = 1'b0;
        for (int i = 0; i < 40; i++) begin pat[i] = 8'(8'h40 + i); upat[i] = 1'b0; end
        send_frame(0, 40, 8'd9, 8'd3, 0, 1, 0);
        idle(6);
        @(negedge clk);
        check("bp_s_tready_low", 64'(s_tready), 64'd0);
        check("bp_m_tvalid", 64'(m_tvalid), 64'd1);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_drain(0, 200);
        idle(3);
        @(negedge clk);
        check("bp_s_tready_back", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;

        // random frames with random gaps on both sides
        rand_rdy = 1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 64);
            for (int i = 0; i < len; i++) begin pat[i] = 8'($urandom); upat[i] = 1'($urandom); end
            send_frame(0, len, 8'($urandom), 8'($urandom), 0, 1, 20);
        end
        rand_rdy = 0;
        @(posedge clk);
        #2;
        m_tready = 1'b1;
        wait_drain(0, 2000);
        idle(4);
        check("rand_bad_pulses", 64'(bad_seen[0]), 64'(exp_bad0));
        check("rand_good_pulses", 64'(good_seen[0]), 64'(exp_good0));
        check("nonframe_overflow", 64'(ovf_seen[0]), 64'd0);

        // reset with a word waiting at the output and a partial frame in the packer
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin pat[i] = 8'(8'h80 + i); upat[i] = 1'b0; end
        send_frame(0, 8, 8'd4, 8'd4, 0, 1, 0);
        send_frame(0, 4, 8'd4, 8'd4, 1, 0, 0);
        idle(2);
        @(negedge clk);
        check("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin pat[i] = 8'(8'h11 * (i + 1)); upat[i] = 1'b0; end
        send_frame(0, 5, 8'd6, 8'd8, 0, 1, 0);
        wait_drain(0, 100);

        // store-and-forward: bad frame dropped, good frame kept, oversize frame dropped
        for (int i = 0; i < 10; i++) begin pat[i] = 8'($urandom); upat[i] = 1'b0; end
        upat[9] = 1'b1;
        send_frame(1, 10, 8'd2, 8'd2, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin pat[i] = 8'($urandom); upat[i] = 1'b0; end
        send_frame(1, 10, 8'd3, 8'd5, 0, 1, 0);
        wait_drain(1, 100);
        for (int i = 0; i < 40; i++) begin pat[i] = 8'($urandom); upat[i] = 1'b0; end
        send_frame(1, 40, 8'd7, 8'd7, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin pat[i] = 8'($urandom); upat[i] = 1'b0; end
        send_frame(1, 5, 8'd8, 8'd1, 0, 1, 0);
        wait_drain(1, 100);
        idle(10);
        check("frame_bad_pulses", 64'(bad_seen[1]), 64'd1);
        check("frame_good_pulses", 64'(good_seen[1]), 64'd2);
        check("frame_overflow_pulses", 64'(ovf_seen[1]), 64'd1);
        check("frame_no_extra_words", 64'(exp2_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_fifo_width_adapter.md
Name: axis_fifo_width_adapter

Overview:
Single-clock AXI4-Stream FIFO with a built-in width converter. It packs narrow input beats (default 8-bit) into wide output words (default 64-bit) and then buffers those words in a FIFO. It sits between a byte-wide MAC/parser datapath and a 64-bit internal datapath. It also supports an optional frame (store-and-forward) mode with bad-frame and full-drop handling.

Parameters:
- DEPTH, 32: FIFO capacity in bytes; word depth = DEPTH/M_KEEP_WIDTH, a power of two, at least 2.
- S_DATA_WIDTH, 8: input data width.
- S_KEEP_ENABLE, (S_DATA_WIDTH>8): use s_axis_tkeep; when 0, tkeep is all ones.
- S_KEEP_WIDTH, S_DATA_WIDTH/8: input tkeep width.
- M_DATA_WIDTH, 64: output data width; must be an integer multiple of S_DATA_WIDTH.
- M_KEEP_ENABLE, (M_DATA_WIDTH>8): drive m_axis_tkeep.
- M_KEEP_WIDTH, M_DATA_WIDTH/8: output tkeep width.
- ID_ENABLE, 1 / ID_WIDTH, 8: tid passthrough enable and width; when disabled, the output is 0.
- DEST_ENABLE, 1 / DEST_WIDTH, 8: tdest passthrough enable and width.
- USER_ENABLE, 1 / USER_WIDTH, 1: tuser passthrough enable and width.
- PIPELINE_OUTPUT, 2: number of output register stages, at least 1.
- FRAME_FIFO, 0: 1 = store-and-forward; output a frame only after its tlast is stored.
- USER_BAD_FRAME_VALUE, 1'b1 / USER_BAD_FRAME_MASK, 1'b1: a frame is bad when (tuser at tlast & MASK) == (VALUE & MASK).
- DROP_BAD_FRAME, 0: drop bad frames. Requires FRAME_FIFO.
- DROP_WHEN_FULL, 0: drop frames that do not fit instead of back-pressuring. Requires FRAME_FIFO.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  S_DATA_WIDTH  input data.
- s_axis_tkeep  in  S_KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of frame.
- s_axis_tid  in  ID_WIDTH  input stream id.
- s_axis_tdest  in  DEST_WIDTH  input destination.
- s_axis_tuser  in  USER_WIDTH  input user bits.
- m_axis_tdata  out  M_DATA_WIDTH  output data.
- m_axis_tkeep  out  M_KEEP_WIDTH  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of frame.
- m_axis_tid  out  ID_WIDTH  output stream id.
- m_axis_tdest  out  DEST_WIDTH  output destination.
- m_axis_tuser  out  USER_WIDTH  output user bits.
- status_overflow  out  1  one-cycle pulse when a frame is dropped because the FIFO is full.
- status_bad_frame  out  1  one-cycle pulse when a bad frame's tlast is accepted.
- status_good_frame  out  1  one-cycle pulse when a good frame's tlast is accepted.

Behaviour:
- Reset, on a clk edge with rst=1:
  - m_axis_tvalid, s_axis_tready and all status outputs go to 0.
  - Pointers, packer state and pipeline registers clear.
  - Any partial frame is discarded.
- Handshake: a transfer occurs when valid && ready on a rising edge. m_axis_* is held stable while tvalid && !tready.
- Packer: bytes are packed little-endian. The first accepted input beat occupies bits [S-1:0], the next [2S-1:S], and so on.
- Word completion: a word completes after M/S beats, or early on a tlast beat.
- Output tkeep: the concatenation of the input tkeep values, with unfilled lanes set to 0. For example, 3 bytes then tlast gives tkeep=8'h07.
- Sideband fields per word:
  - tid and tdest are taken from the word's first beat.
  - tuser and tlast are taken from the word's final beat.
- Completed words are written to FIFO memory on the next edge.
- s_axis_tready is low only while a completed word cannot be written because the FIFO is full (and DROP_WHEN_FULL=0). The packer must not lose data in this case.
- Full and empty detection uses read/write pointers one bit wider than the address. The FIFO is full when the MSBs differ and the remaining bits are equal; pointer wrap is natural modulo.
- Latency: a word written at edge E1 makes m_axis_tvalid high after edge E1+PIPELINE_OUTPUT when the output is idle. Sustained throughput is one output word per cycle.
- Simultaneous read and write while full: the write is permitted only after the read frees space. s_axis_tready must not combinationally depend on m_axis_tready.
- FRAME_FIFO=1:
  - Reads are gated by a committed write pointer, which advances only when a tlast word is written.
  - A frame larger than the FIFO is always dropped, and status_overflow pulses.
  - DROP_WHEN_FULL=1: when the FIFO fills mid-frame, s_axis_tready stays 1. The rest of the frame is discarded, the write pointer rolls back to the committed pointer, and status_overflow pulses at tlast.
  - DROP_BAD_FRAME=1: on a bad tlast, the pointer rolls back and status_bad_frame pulses.
  - status_good_frame pulses when a committed frame is good.
- FRAME_FIFO=0: status_bad_frame and status_good_frame still pulse on each accepted tlast, according to the tuser check. status_overflow stays 0.
- rst mid-frame: the output deasserts tvalid on the reset edge, and no partial word is emitted afterwards.

Test Plan:
- Single 8-byte frame, bytes 0x01..0x08, tlast on 0x08, tid=5, tdest=7, tuser=0 -> one word: tdata=64'h0807060504030201, tkeep=8'hFF, tlast=1, tid=5, tdest=7, tuser=0.
- 3-byte frame AA BB CC with tuser=1 on tlast -> tdata low bytes 24'hCCBBAA, tkeep=8'h07, tuser=1, tlast=1, status_bad_frame pulse.
- m_axis_tready=0 while 40 bytes are sent -> s_axis_tready drops after 32 bytes are buffered (4 words). Then tready=1 -> all 5 words emerge in order, with no loss.
- 1000 random-length frames (1..64 bytes) with random tvalid/tready gaps -> byte stream, tkeep and tlast match the reference model exactly.
- FRAME_FIFO=1, DROP_BAD_FRAME=1: a bad 10-byte frame then a good 10-byte frame -> only the good frame is output, status_bad_frame pulses once.
- rst asserted mid-frame after 4 bytes -> m_axis_tvalid=0 on the next cycle. The next frame is output cleanly with no residue.
